// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
//
// A start strobe latches the operand magnitudes. A radix-2 restoring
// division then runs for 32 cycles, one quotient bit per cycle. The
// signed/special-case fix-up is applied as the last iteration completes,
// and the result is presented in `out` with a one-cycle `done` pulse.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   x      in  32   dividend, sampled when start is accepted
//   y      in  32   divisor, sampled when start is accepted
//   fn     in   2   0 DIV, 1 DIVU, 2 REM, 3 REMU
//   start  in   1   request, accepted when busy=0
//   busy   out  1   division in progress
//   done   out  1   one-cycle pulse, out valid
//   out    out 32   result register, held until the next done
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [1:0]  fn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic        rem_op_q, rem_op_d;      // fn[1]: remainder requested
  logic        sign_quo_q, sign_quo_d;  // quotient must be negated
  logic        sign_rem_q, sign_rem_d;  // remainder must be negated
  logic        div0_q, div0_d;
  logic [31:0] quo_q, quo_d;            // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;            // divisor magnitude
  logic [31:0] rem_q, rem_d;            // partial remainder
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;

  logic               op_signed;
  logic signed [32:0] trial;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  assign op_signed = ~fn[0];

  // The shifted remainder is compared against the divisor in 33 bits. The
  // true difference always lies in (-2^32, 2^32), so bit 32 is its sign.
  assign trial = $signed({rem_q, quo_q[31]}) - $signed({1'b0, dvs_q});

  always_comb begin
    state_d    = state_q;
    rem_op_d   = rem_op_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    div0_d     = div0_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    out_d      = out_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = CALC;
          rem_op_d   = fn[1];
          quo_d      = mag32(x, op_signed);
          dvs_d      = mag32(y, op_signed);
          sign_quo_d = op_signed & (x[31] ^ y[31]);
          sign_rem_d = op_signed & x[31];
          div0_d     = (y == 32'd0);
          rem_d      = 32'd0;
          cnt_d      = 5'd31;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        quo_d = {quo_q[30:0], ~trial[32]};
        rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          // Divide-by-zero leaves rem = |x| and a quotient of all ones, so
          // only the quotient needs an explicit override.
          if (rem_op_d)
            out_d = sign_rem_q ? neg32(rem_d) : rem_d;
          else if (div0_q)
            out_d = 32'hFFFF_FFFF;
          else
            out_d = sign_quo_q ? neg32(quo_d) : quo_d;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_op_q   <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 5'd0;
      out_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      rem_op_q   <= rem_op_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      div0_q     <= div0_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed cases cover the
// documented examples and corner cases; a random sweep compares against a
// plain-arithmetic RV32M reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x, y;
  logic [1:0]  fn;
  logic        start;
  logic        busy, done;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .fn(fn),
    .start(start), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  // RV32M semantics from the ISA rules, not from the datapath.
  function automatic logic [31:0] ref_model(input logic [31:0] a, b, input logic [1:0] f);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0)
      return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Invariants on every cycle out of reset.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, required not both 1", busy, done);
      end
      checks++;
      if (done && prev_done) begin
        errors++;
        $display("FAIL done_two_cycles: done high on consecutive cycles, required single pulse");
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Start one op; returns the result at the done cycle, the number of cycles
  // from acceptance to done (33 = done right after edge k+32) and busy cycles.
  // poke>0 pulses start with junk operands on that cycle of CALC.
  task automatic run_op(input logic [31:0] a, b, input logic [1:0] f, input int poke,
                        output logic [31:0] res, output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    res = 32'hDEAD_BEEF;
    @(negedge clk);
    x = a; y = b; fn = f; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      x = $urandom; y = $urandom; fn = 2'($urandom);
      start = (i == poke);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        res = out;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, b, input logic [1:0] f,
                          input logic [31:0] exp, input int poke);
    logic [31:0] res;
    int lat, nbusy;
    run_op(a, b, f, poke, res, lat, nbusy);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s: out=%h required %h", name, res, exp);
    end
    checks++;
    if (lat !== 33 || nbusy !== 32) begin
      errors++;
      $display("FAIL %s_latency: done at %0d busy %0d, required 33 and 32", name, lat, nbusy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; fn = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b out=%h required 0 0 0", busy, done, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] held;
    check_op("divu_100_7", 32'd100, 32'd7, 2'd1, 32'd14, 0);
    held = out;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out !== held) begin
      errors++;
      $display("FAIL hold_after_done: done=%b out=%h required 0 %h", done, out, held);
    end
    check_op("remu_100_7", 32'd100, 32'd7, 2'd3, 32'd2, 0);
    check_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 2'd0, 32'hFFFF_FFFD, 0);
    check_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 2'd2, 32'hFFFF_FFFF, 0);
    check_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 2'd0, 32'hFFFF_FFFD, 0);
    check_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 2'd2, 32'd1, 0);
  endtask

  task automatic test_div0_overflow();
    check_op("div_by0", 32'hFFFF_FFFB, 32'd0, 2'd0, 32'hFFFF_FFFF, 0);
    check_op("divu_by0", 32'hFFFF_FFFB, 32'd0, 2'd1, 32'hFFFF_FFFF, 0);
    check_op("rem_by0", 32'hFFFF_FFFB, 32'd0, 2'd2, 32'hFFFF_FFFB, 0);
    check_op("remu_by0", 32'hFFFF_FFFB, 32'd0, 2'd3, 32'hFFFF_FFFB, 0);
    check_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'h8000_0000, 0);
    check_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'd0, 0);
  endtask

  task automatic test_start_ignored();
    check_op("poke_mid_calc", 32'd1000, 32'd33, 2'd1, 32'd30, 10);
    check_op("poke_last_iter", 32'hFFFF_FF9C, 32'd9, 2'd2, 32'hFFFF_FFFF, 31);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    @(negedge clk);
    x = 32'd5000; y = 32'd7; fn = 2'd1; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin t1 = i; break; end
    end
    checks++;
    if (t1 !== 33 || out !== 32'd714) begin
      errors++;
      $display("FAIL b2b_first: done at %0d out=%h required 33 %h", t1, out, 32'd714);
    end
    x = 32'hFFFF_FF00; y = 32'd3; fn = 2'd2; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy: busy=%b required 1", busy);
        end
      end
      start = 1'b0;
      if (done) begin t2 = i; break; end
    end
    checks++;
    if (t2 !== 33 || out !== ref_model(32'hFFFF_FF00, 32'd3, 2'd2)) begin
      errors++;
      $display("FAIL b2b_second: done %0d cycles after first, out=%h required 33 %h",
               t2, out, ref_model(32'hFFFF_FF00, 32'd3, 2'd2));
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    @(negedge clk);
    x = 32'd123456; y = 32'd10; fn = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%b done=%b out=%h required 0 0 0", busy, done, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: %0d active cycles required 0", seen);
    end
    check_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 2'd1, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, res, exp;
    logic [1:0]  f;
    int lat, nbusy, bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      f = 2'($urandom);
      exp = ref_model(a, b, f);
      run_op(a, b, f, (i % 7 == 0) ? int'($urandom_range(1, 31)) : 0, res, lat, nbusy);
      checks++;
      if (res !== exp || lat !== 33) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_op: x=%h y=%h fn=%0d out=%h lat=%0d required %h lat=33",
                   a, b, f, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_calc();
    test_random(1200);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
